// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// idle line level. Used by both the RX and TX halves of the serial link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam int   PAYLOAD_W       = 9;
    localparam logic LINE_IDLE       = 1'b1;

    // True when the received parity bit disagrees with the configured sense
    // (odd = 0 expects an even count of ones over data plus parity bit).
    function automatic logic parity_error(
        input logic [FRAME_DATA_BITS-1:0] data,
        input logic                       pbit,
        input logic                       odd
    );
        return (^data ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Rx metastability synchroniser and divClk rising-edge detector. The tick
// output is a registered one-Clk pulse per divClk rising edge.
module uart_sync_edge
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic div_clk_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   div_q;
    logic                   tick_q;

    // Synchroniser chain resets to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops sample their inputs from the same edge.
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    // Rising-edge detect on the oversample strobe, registered into tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_clk_i;
            tick_q <= div_clk_i & ~div_q;
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];
    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: start, 8 data bits LSB first, parity, stop. Samples each bit
// at its centre using the oversample tick and publishes the 9-bit payload
// {parity, data} with parity/framing flags on a one-Clk Valid pulse.
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 divClk,
    input  logic                 Rx,
    output logic [PAYLOAD_W-1:0] Dout,
    output logic                 Valid,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int             CW        = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

    logic rx_s;
    logic tick;

    uart_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .div_clk_i (divClk),
        .rx_i      (Rx),
        .rx_s_o    (rx_s),
        .tick_o    (tick)
    );

    rx_state_t                  state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       pbit_q, pbit_d;
    // Cleared by a low stop bit; the line must read idle on a tick before a
    // new start is accepted, so a held break cannot retrigger the receiver.
    logic                       armed_q, armed_d;
    logic [PAYLOAD_W-1:0]       dout_q, dout_d;
    logic                       valid_q, valid_d;
    logic                       perr_q, perr_d;
    logic                       ferr_q, ferr_d;

    // Frame sequencing: next state, bit counters, shift register and results.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pbit_d    = pbit_q;
        armed_d   = armed_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (tick && rx_s == LINE_IDLE) begin
                    armed_d = 1'b1;
                end
                if (rx_s != LINE_IDLE && armed_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = '0;
                        if (rx_s != LINE_IDLE) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d            = '0;
                        shift_d[bit_idx_q] = rx_s;
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = PARITY;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        pbit_d  = rx_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        dout_d  = {pbit_q, shift_q};
                        perr_d  = parity_error(shift_q, pbit_q, PARITY_ODD);
                        ferr_d  = ~rx_s;
                        valid_d = 1'b1;
                        armed_d = rx_s;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            pbit_q    <= 1'b0;
            armed_q   <= 1'b1;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            pbit_q    <= pbit_d;
            armed_q   <= armed_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Dout      = dout_q;
    assign Valid     = valid_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Busy      = (state_q != IDLE);

endmodule
